// File: rtl/jk_updown_counter.sv
// jk_updown_counter: synchronous modulo-MODULUS up/down counter made of WIDTH
// JK stages. Each cycle the J/K excitation is computed for every stage and the
// JK characteristic equation produces the next state.
// Optional build macro: JK_UPDOWN_COUNTER_EXCITE_OUT_EN exposes the per-stage
// excitation on j_out/k_out.
module jk_updown_counter #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             tc,
    output logic             wrap
`ifdef JK_UPDOWN_COUNTER_EXCITE_OUT_EN
    ,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out
`endif
);

    // Largest legal count; comparing against it keeps every test within WIDTH bits
    // even when MODULUS == 2^WIDTH.
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] j_c;
    logic [WIDTH-1:0] k_c;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] target;
    logic             wrap_next;
    logic             at_max;
    logic             at_zero;
    logic             out_of_range;

    assign at_max       = (q == MAX_VAL);
    assign at_zero      = (q == '0);
    assign out_of_range = (q > MAX_VAL);

    // Load value clamped into the count range.
    assign target = (din > MAX_VAL) ? MAX_VAL : din;

    // Per-stage J/K excitation and wrap detection; priority rst > load > en > hold.
    always_comb begin : excitation
        logic carry;
        j_c       = '0;
        k_c       = '0;
        wrap_next = 1'b0;
        carry     = 1'b1;
        if (rst) begin
            k_c = '1;
        end else if (load) begin
            j_c = target;
            k_c = ~target;
        end else if (en) begin
            if (out_of_range) begin
                // Recover from an illegal state by clearing every stage.
                k_c = '1;
            end else if (up) begin
                if (at_max) begin
                    k_c       = q;
                    wrap_next = 1'b1;
                end else begin
                    // Stage i toggles when all lower stages are one.
                    for (int i = 0; i < int'(WIDTH); i++) begin
                        j_c[i] = carry;
                        k_c[i] = carry;
                        carry  = carry & q[i];
                    end
                end
            end else begin
                if (at_zero) begin
                    j_c       = MAX_VAL;
                    wrap_next = 1'b1;
                end else begin
                    // Stage i toggles when all lower stages are zero.
                    for (int i = 0; i < int'(WIDTH); i++) begin
                        j_c[i] = carry;
                        k_c[i] = carry;
                        carry  = carry & ~q[i];
                    end
                end
            end
        end
    end

    // JK characteristic equation applied to every stage.
    assign q_next = (j_c & ~q) | (~k_c & q);

    // Terminal count: the next enabled step in the current direction wraps.
    assign tc = en & ~load & (up ? at_max : at_zero);

    // State, complement and wrap pulse registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            q     <= '0;
            q_bar <= '1;
            wrap  <= 1'b0;
        end else begin
            q     <= q_next;
            q_bar <= ~q_next;
            wrap  <= wrap_next;
        end
    end

`ifdef JK_UPDOWN_COUNTER_EXCITE_OUT_EN
    assign j_out = j_c;
    assign k_out = k_c;
`endif

endmodule
